// File: rtl/dmem_block_responder_if.sv
//------------------------------------------------------------------------------
// Module   : dmem_block_responder_if
// Purpose  : Block refill/write-back bus between the data cache and the memory.
//            mem_error exists only when DMEM_RANGE_CHECK_EN is defined.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface dmem_block_responder_if;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_address;
    logic [127:0] mem_WRITE_DATA;
    logic [127:0] mem_READ_DATA;
    logic         mem_busywait;
`ifdef DMEM_RANGE_CHECK_EN
    logic         mem_error;
`endif

    // Cache side drives requests, memory side answers them.
    modport master (
        output mem_read,
        output mem_write,
        output mem_address,
        output mem_WRITE_DATA,
        input  mem_READ_DATA,
`ifdef DMEM_RANGE_CHECK_EN
        input  mem_error,
`endif
        input  mem_busywait
    );

    modport slave (
        input  mem_read,
        input  mem_write,
        input  mem_address,
        input  mem_WRITE_DATA,
        output mem_READ_DATA,
`ifdef DMEM_RANGE_CHECK_EN
        output mem_error,
`endif
        output mem_busywait
    );
endinterface

`default_nettype wire

// File: rtl/dmem_block_responder.sv
//------------------------------------------------------------------------------
// Module   : dmem_block_responder
// Purpose  : 128-bit block data memory with fixed access latency and busywait
//            handshake. Optional macro DMEM_RANGE_CHECK_EN adds mem_error.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module dmem_block_responder #(
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 5
) (
    input  logic                   CLOCK,
    input  logic                   RESET,
    dmem_block_responder_if.slave  bus
);

    localparam int         DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [3:0] COUNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [3:0]              counter;
    logic [3:0]              counter_next;
    logic                    busywait;

    logic                    cap_read;
    logic                    cap_write;
    logic [DEPTH_LOG2-1:0]   cap_idx;
    logic [127:0]            cap_data;
    logic                    cap_bad;

    logic [127:0]            storage [DEPTH];
    logic [127:0]            read_data;

    logic                    capture;
    logic                    complete;
    logic                    write_fire;
    logic                    read_fire;
    logic                    zero_fire;
    logic                    request_bad;

    assign capture  = (state == IDLE) && (bus.mem_read || bus.mem_write);
    assign complete = (state == BUSY) && (counter == 4'd0);

`ifdef DMEM_RANGE_CHECK_EN
    // Out-of-range blocks and conflicting read+write are flagged, not served.
    assign request_bad = (|bus.mem_address[27:DEPTH_LOG2]) ||
                         (bus.mem_read && bus.mem_write);
`else
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.mem_address[27:DEPTH_LOG2];
    assign request_bad    = 1'b0;
`endif

    assign write_fire = complete && cap_write && !cap_bad;
    assign read_fire  = complete && cap_read  && !cap_bad;
    assign zero_fire  = complete && cap_read  &&  cap_bad;

    //--------------------------------------------------------------------------
    // FSM state register
    //--------------------------------------------------------------------------
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state   <= IDLE;
            counter <= 4'd0;
        end else begin
            state   <= state_next;
            counter <= counter_next;
        end
    end

    //--------------------------------------------------------------------------
    // FSM next state and busywait
    //--------------------------------------------------------------------------
    always_comb begin
        state_next   = state;
        counter_next = counter;
        busywait     = 1'b0;
        case (state)
            IDLE: begin
                busywait = bus.mem_read || bus.mem_write;
                if (bus.mem_read || bus.mem_write) begin
                    state_next   = BUSY;
                    counter_next = COUNT_LOAD;
                end
            end
            BUSY: begin
                busywait = 1'b1;
                if (counter == 4'd0) begin
                    state_next = DONE;
                end else begin
                    counter_next = counter - 4'd1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // Request capture: later bus changes during BUSY are ignored
    //--------------------------------------------------------------------------
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            cap_read  <= 1'b0;
            cap_write <= 1'b0;
            cap_idx   <= '0;
            cap_data  <= '0;
            cap_bad   <= 1'b0;
        end else if (capture) begin
`ifdef DMEM_RANGE_CHECK_EN
            cap_read  <= bus.mem_read;
`else
            cap_read  <= bus.mem_read && !bus.mem_write;
`endif
            cap_write <= bus.mem_write;
            cap_idx   <= bus.mem_address[DEPTH_LOG2-1:0];
            cap_data  <= bus.mem_WRITE_DATA;
            cap_bad   <= request_bad;
        end
    end

    // Storage is deliberately not reset; write_fire is already false under reset.
    always_ff @(posedge CLOCK) begin
        if (write_fire) begin
            storage[cap_idx] <= cap_data;
        end
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            read_data <= '0;
        end else if (read_fire) begin
            read_data <= storage[cap_idx];
        end else if (zero_fire) begin
            read_data <= '0;
        end
    end

`ifdef DMEM_RANGE_CHECK_EN
    logic error_flag;

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            error_flag <= 1'b0;
        end else begin
            error_flag <= complete && cap_bad;
        end
    end

    assign bus.mem_error = error_flag;
`endif

    assign bus.mem_READ_DATA = read_data;
    assign bus.mem_busywait  = busywait;

endmodule

`default_nettype wire

// File: tb/tb_dmem_block_responder.sv
//------------------------------------------------------------------------------
// Module   : tb_dmem_block_responder
// Purpose  : Directed and randomized checks of dmem_block_responder against
//            an array-based reference model.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_dmem_block_responder;

    localparam int DEPTH_LOG2 = 8;
    localparam int LATENCY    = 5;

    logic CLOCK = 1'b0;
    logic RESET = 1'b0;

    always #5 CLOCK = ~CLOCK;

    dmem_block_responder_if bus ();

    dmem_block_responder #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .LATENCY    (LATENCY)
    ) dut (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .bus   (bus)
    );

    logic [127:0] model_mem [256];
    logic [127:0] model_rdata;
    logic         model_err;

    int checks = 0;
    int passed = 0;
    int failed = 0;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Effect of one completed request on the memory image and read register.
    task automatic model_apply(input logic rd, input logic wr,
                               input logic [27:0] addr, input logic [127:0] data);
        logic err;
        err = 1'b0;
`ifdef DMEM_RANGE_CHECK_EN
        err = (addr[27:8] != 20'd0) || (rd && wr);
`endif
        if (err) begin
            if (rd) model_rdata = '0;
        end else if (wr) begin
            model_mem[addr[7:0]] = data;
        end else if (rd) begin
            model_rdata = model_mem[addr[7:0]];
        end
        model_err = err;
    endtask

    // Called in the request cycle after the IDLE busywait check; returns at the
    // DONE-cycle negedge with the request withdrawn.
    task automatic run_to_done(input string tag, input logic rd, input logic wr,
                               input logic [27:0] addr, input logic [127:0] data);
        int  busy_cycles;
        bit  finished;
        busy_cycles = 0;
        finished    = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLOCK);
            if (!bus.mem_busywait) begin
                finished = 1'b1;
                break;
            end
            busy_cycles++;
            bus.mem_address    = 28'($urandom);
            bus.mem_WRITE_DATA = rand128();
        end
        chk1({tag, " completes"}, finished, 1'b1);
        chk32({tag, " busy cycles"}, busy_cycles, LATENCY);
        model_apply(rd, wr, addr, data);
        chk128({tag, " read data"}, bus.mem_READ_DATA, model_rdata);
`ifdef DMEM_RANGE_CHECK_EN
        chk1({tag, " error"}, bus.mem_error, model_err);
`endif
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
    endtask

    task automatic issue(input string tag, input logic rd, input logic wr,
                         input logic [27:0] addr, input logic [127:0] data);
        @(negedge CLOCK);
        bus.mem_read       = rd;
        bus.mem_write      = wr;
        bus.mem_address    = addr;
        bus.mem_WRITE_DATA = data;
        #1;
        chk1({tag, " request busywait"}, bus.mem_busywait, rd | wr);
        run_to_done(tag, rd, wr, addr, data);
    endtask

    initial begin
        logic [127:0] pattern;
        logic [127:0] blk11;
        logic [27:0]  raddr;
        logic [1:0]   op;

        pattern     = 128'h0123456789ABCDEF0123456789ABCDEF;
        model_rdata = '0;
        model_err   = 1'b0;
        for (int i = 0; i < 256; i++) model_mem[i] = 'x;

        bus.mem_read       = 1'b0;
        bus.mem_write      = 1'b0;
        bus.mem_address    = '0;
        bus.mem_WRITE_DATA = '0;

        // Reset state
        repeat (3) @(negedge CLOCK);
        chk1("reset busywait", bus.mem_busywait, 1'b0);
        chk128("reset read data", bus.mem_READ_DATA, 128'h0);
`ifdef DMEM_RANGE_CHECK_EN
        chk1("reset error", bus.mem_error, 1'b0);
`endif
        RESET = 1'b1;

        // First read after reset: timing and a defined busywait
        issue("read05", 1'b1, 1'b0, 28'h05, '0);
        chk1("busywait known", $isunknown(bus.mem_busywait), 1'b0);

        // Populate every block
        for (int i = 0; i < 256; i++) begin
            issue("fill", 1'b0, 1'b1, 28'(i), rand128());
        end

        // Write then read back a known pattern
        issue("write2A", 1'b0, 1'b1, 28'h2A, pattern);
        issue("read2A", 1'b1, 1'b0, 28'h2A, '0);
        chk128("read2A pattern", bus.mem_READ_DATA, pattern);

        // Write-back followed by refill raised during DONE
        blk11 = rand128();
        issue("write11", 1'b0, 1'b1, 28'h11, blk11);
        bus.mem_read    = 1'b1;
        bus.mem_address = 28'h11;
        #1;
        chk1("refill gap busywait", bus.mem_busywait, 1'b0);
        @(negedge CLOCK);
        chk1("refill idle busywait", bus.mem_busywait, 1'b1);
        run_to_done("refill11", 1'b1, 1'b0, 28'h11, '0);
        chk128("refill11 data", bus.mem_READ_DATA, blk11);

        // Reset in the middle of a write aborts it
        @(negedge CLOCK);
        bus.mem_write      = 1'b1;
        bus.mem_address    = 28'h3C;
        bus.mem_WRITE_DATA = ~model_mem[8'h3C];
        repeat (2) @(negedge CLOCK);
        RESET = 1'b0;
        #1;
        chk1("abort busywait idle rule", bus.mem_busywait, 1'b1);
        chk128("abort read data", bus.mem_READ_DATA, 128'h0);
        bus.mem_write = 1'b0;
        #1;
        chk1("abort busywait released", bus.mem_busywait, 1'b0);
        repeat (2) @(negedge CLOCK);
        RESET       = 1'b1;
        model_rdata = '0;
        model_err   = 1'b0;
        issue("read3C", 1'b1, 1'b0, 28'h3C, '0);

        // Read and write together
        pattern = rand128();
        issue("readwrite07", 1'b1, 1'b1, 28'h07, 128'hA5);
        chk128("readwrite07 rdata held", bus.mem_READ_DATA, model_rdata);
        issue("read07", 1'b1, 1'b0, 28'h07, '0);

        // Address above the implemented depth
        issue("read100", 1'b1, 1'b0, 28'h0000100, '0);

        // Randomized traffic
        for (int i = 0; i < 60; i++) begin
            op    = 2'($urandom_range(1, 3));
            raddr = ($urandom_range(0, 3) == 0) ? 28'($urandom) : 28'($urandom_range(0, 255));
            issue("random", op[0], op[1], raddr, rand128());
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

`default_nettype wire
